// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader_if
//  Purpose  : Byte-stream load handshake, CPU fetch port and loader status
//             grouped into one bundle with host (master) and loader (slave)
//             views.
//  Revision : 1.0  initial release
// ============================================================================
interface prog_loader_if #(
    parameter int ADDR_W = 4
);
    logic              load_req;
    logic              byte_valid;
    logic [7:0]        byte_in;
    logic              byte_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              cpu_run;
    logic              loading;
    logic              done;
    logic              error;
    logic [7:0]        checksum;

    modport master (
        output load_req, byte_valid, byte_in, rd_addr,
        input  byte_ready, rd_data, cpu_run, loading, done, error, checksum
    );

    modport slave (
        input  load_req, byte_valid, byte_in, rd_addr,
        output byte_ready, rd_data, cpu_run, loading, done, error, checksum
    );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Program RAM writer for the instruction-fetch path. Loads DEPTH
//             bytes plus a two's-complement checksum byte from a valid/ready
//             stream, holds the CPU in reset until the image checks out, and
//             serves combinational reads by PC.
//  Revision : 1.0  initial release
// ============================================================================
module prog_loader #(
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic   clk,
    input  wire logic   rst,
    prog_loader_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_RUN   = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t            r_state,    w_state_nxt;
    logic [ADDR_W-1:0] r_wptr,     w_wptr_nxt;
    logic [7:0]        r_checksum, w_checksum_nxt;
    logic [CNT_W-1:0]  r_idle_cnt, w_idle_cnt_nxt;
    logic [7:0]        r_mem [DEPTH];

    logic       w_streaming;
    logic       w_ready;
    logic       w_accept;
    logic [7:0] w_sum;
    logic       w_timeout;

    assign w_streaming = (r_state == S_LOAD) || (r_state == S_CHECK);
    // A restart request always wins over a byte offered in the same cycle.
    assign w_ready     = w_streaming && !bus.load_req;
    assign w_accept    = w_ready && bus.byte_valid;
    assign w_sum       = r_checksum + bus.byte_in;
    // Next idle cycle would reach the limit, so abort on this edge.
    assign w_timeout   = (r_idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wptr     <= '0;
            r_checksum <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wptr     <= w_wptr_nxt;
            r_checksum <= w_checksum_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
        end
    end

    // Next-state, write pointer, running sum and idle-counter logic
    always_comb begin
        w_state_nxt    = r_state;
        w_wptr_nxt     = r_wptr;
        w_checksum_nxt = r_checksum;
        w_idle_cnt_nxt = r_idle_cnt;

        if (bus.load_req) begin
            w_state_nxt    = S_LOAD;
            w_wptr_nxt     = '0;
            w_checksum_nxt = '0;
            w_idle_cnt_nxt = '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        w_wptr_nxt     = r_wptr + ADDR_W'(1);
                        w_checksum_nxt = w_sum;
                        w_idle_cnt_nxt = '0;
                        if (r_wptr == ADDR_W'(DEPTH - 1)) begin
                            w_state_nxt = S_CHECK;
                        end
                    end else begin
                        w_idle_cnt_nxt = r_idle_cnt + CNT_W'(1);
                        if (w_timeout) begin
                            w_state_nxt = S_ERROR;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_accept) begin
                        w_checksum_nxt = w_sum;
                        w_idle_cnt_nxt = '0;
                        w_state_nxt    = (w_sum == 8'h00) ? S_RUN : S_ERROR;
                    end else begin
                        w_idle_cnt_nxt = r_idle_cnt + CNT_W'(1);
                        if (w_timeout) begin
                            w_state_nxt = S_ERROR;
                        end
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    // Program RAM write port; contents survive reset by design
    always_ff @(posedge clk) begin
        if (w_accept && (r_state == S_LOAD)) begin
            r_mem[r_wptr] <= bus.byte_in;
        end
    end

    assign bus.byte_ready = w_ready;
    assign bus.rd_data    = r_mem[bus.rd_addr];
    assign bus.cpu_run    = (r_state == S_RUN);
    assign bus.done       = (r_state == S_RUN);
    assign bus.error      = (r_state == S_ERROR);
    assign bus.loading    = w_streaming;
    assign bus.checksum   = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Self-checking bench for prog_loader with a scoreboard queue of
//             expected status / RAM values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_loader;

    localparam int DEPTH          = 16;
    localparam int ADDR_W         = 4;
    localparam int TIMEOUT_CYCLES = 8;

    localparam int K_DONE = 0, K_ERR = 1, K_RUN = 2, K_LOADING = 3,
                   K_CSUM = 4, K_RD = 5, K_READY = 6, K_ACC = 7;

    typedef struct {
        string      tag;
        int         kind;
        logic [7:0] exp;
        logic [3:0] addr;
    } sb_item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    prog_loader #(
        .DEPTH         (DEPTH),
        .ADDR_W        (ADDR_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #50 clk = ~clk;

    sb_item_t   sb_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         acc_cnt = 0;
    logic [7:0] img [DEPTH];

    task automatic check_value(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int kind, input logic [7:0] exp,
                           input logic [3:0] addr = 4'd0);
        sb_item_t it;
        it.tag = tag; it.kind = kind; it.exp = exp; it.addr = addr;
        sb_q.push_back(it);
    endtask

    // Pop every pending expectation and compare against the live DUT output.
    task automatic sb_drain();
        sb_item_t   it;
        logic [7:0] obs;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            if (it.kind == K_RD) bus.rd_addr = it.addr;
            #1;
            case (it.kind)
                K_DONE:    obs = {7'd0, bus.done};
                K_ERR:     obs = {7'd0, bus.error};
                K_RUN:     obs = {7'd0, bus.cpu_run};
                K_LOADING: obs = {7'd0, bus.loading};
                K_CSUM:    obs = bus.checksum;
                K_RD:      obs = bus.rd_data;
                K_READY:   obs = {7'd0, bus.byte_ready};
                default:   obs = acc_cnt[7:0];
            endcase
            check_value(it.tag, obs, it.exp);
        end
    endtask

    task automatic pulse_load();
        bus.load_req   = 1'b1;
        bus.byte_valid = 1'b0;
        @(negedge clk);
        bus.load_req   = 1'b0;
    endtask

    task automatic idle_cycle();
        bus.byte_valid = 1'b0;
        @(negedge clk);
    endtask

    // Offer one byte and hold it until the loader takes it (bounded wait).
    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.byte_ready) begin
                got = 1'b1;
                acc_cnt++;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
        if (!got) check_value("byte_accept_timeout", 8'd0, 8'd1);
    endtask

    // Stream img[] then its two's-complement checksum (or a forced check byte).
    task automatic send_image(input bit gaps, input bit force_chk, input logic [7:0] chk_in);
        logic [7:0] sum = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            send_byte(img[i]);
            sum = sum + img[i];
            sb_push("loading_stream", K_LOADING, 8'd1);
            sb_drain();
            if (gaps) idle_cycle();
        end
        send_byte(force_chk ? chk_in : (8'h00 - sum));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.load_req   = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        bus.rd_addr    = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        sb_push("rst_done", K_DONE, 8'd0);
        sb_push("rst_error", K_ERR, 8'd0);
        sb_push("rst_cpu_run", K_RUN, 8'd0);
        sb_push("rst_loading", K_LOADING, 8'd0);
        sb_push("rst_checksum", K_CSUM, 8'h00);
        sb_push("rst_ready", K_READY, 8'd0);
        sb_drain();

        // 1: good image 0x00..0x0F with check byte 0x88
        pulse_load();
        sb_push("t1_loading", K_LOADING, 8'd1);
        sb_push("t1_ready", K_READY, 8'd1);
        sb_drain();
        for (int i = 0; i < DEPTH; i++) img[i] = 8'(i);
        send_image(1'b0, 1'b1, 8'h88);
        sb_push("t1_done", K_DONE, 8'd1);
        sb_push("t1_cpu_run", K_RUN, 8'd1);
        sb_push("t1_checksum", K_CSUM, 8'h00);
        sb_push("t1_loading_off", K_LOADING, 8'd0);
        sb_push("t1_ready_run", K_READY, 8'd0);
        sb_push("t1_rd5", K_RD, 8'h05, 4'd5);
        sb_push("t1_rd15", K_RD, 8'h0F, 4'd15);
        sb_drain();

        // 2: same bytes, bad check byte 0x00
        pulse_load();
        send_image(1'b0, 1'b1, 8'h00);
        sb_push("t2_error", K_ERR, 8'd1);
        sb_push("t2_cpu_run", K_RUN, 8'd0);
        sb_push("t2_done", K_DONE, 8'd0);
        sb_push("t2_checksum", K_CSUM, 8'h78);
        sb_drain();
        pulse_load();
        sb_push("t2_error_clr", K_ERR, 8'd0);
        sb_push("t2_reload", K_LOADING, 8'd1);
        sb_drain();

        // 3: timeout 8 cycles after the third byte
        send_byte(8'hA1);
        send_byte(8'hB2);
        send_byte(8'hC3);
        for (int k = 1; k <= TIMEOUT_CYCLES; k++) begin
            idle_cycle();
            if (k == TIMEOUT_CYCLES - 1) sb_push("t3_no_error_yet", K_ERR, 8'd0);
            if (k == TIMEOUT_CYCLES) begin
                sb_push("t3_error", K_ERR, 8'd1);
                sb_push("t3_ready_off", K_READY, 8'd0);
                sb_push("t3_loading_off", K_LOADING, 8'd0);
            end
            sb_drain();
        end

        // 4: valid toggling with one-cycle gaps
        pulse_load();
        acc_cnt = 0;
        for (int i = 0; i < DEPTH; i++) img[i] = 8'h30 + 8'(3 * i);
        send_image(1'b1, 1'b0, 8'h00);
        sb_push("t4_accepts", K_ACC, 8'd17);
        sb_push("t4_done", K_DONE, 8'd1);
        sb_push("t4_checksum", K_CSUM, 8'h00);
        for (int i = 0; i < DEPTH; i += 5) sb_push("t4_rd", K_RD, img[i], 4'(i));
        sb_drain();

        // 5: restart mid-load with a byte offered alongside load_req
        pulse_load();
        for (int i = 0; i < 5; i++) send_byte(8'h11 * 8'(i + 1));
        bus.load_req   = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'hEE;
        sb_push("t5_ready_blocked", K_READY, 8'd0);
        sb_drain();
        @(negedge clk);
        bus.load_req   = 1'b0;
        bus.byte_valid = 1'b0;
        sb_push("t5_checksum_clr", K_CSUM, 8'h00);
        sb_push("t5_loading", K_LOADING, 8'd1);
        sb_drain();
        for (int i = 0; i < DEPTH; i++) img[i] = 8'hC5 ^ 8'(7 * i);
        send_image(1'b0, 1'b0, 8'h00);
        sb_push("t5_done", K_DONE, 8'd1);
        sb_push("t5_rd0", K_RD, img[0], 4'd0);
        sb_push("t5_rd9", K_RD, img[9], 4'd9);
        sb_drain();

        // 6: reset after 7 bytes
        pulse_load();
        for (int i = 0; i < 7; i++) send_byte(8'h50 + 8'(i));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_push("t6_cpu_run", K_RUN, 8'd0);
        sb_push("t6_loading", K_LOADING, 8'd0);
        sb_push("t6_done", K_DONE, 8'd0);
        sb_push("t6_error", K_ERR, 8'd0);
        sb_push("t6_checksum", K_CSUM, 8'h00);
        sb_push("t6_rd3", K_RD, 8'h53, 4'd3);
        sb_push("t6_ready", K_READY, 8'd0);
        sb_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
